// File: rtl/control_sequencer.sv
// Microcoded-style control sequencer for a small single-bus datapath.
// Walks a fetch (F0..F2), decode (DEC) and execute (E0..E2) sequence and
// decodes every datapath strobe combinationally from state, opcode and S.
//
// Ports:
//   clk                      rising-edge clock for all state
//   reset                    asynchronous active-high reset, forces IDLE
//   run                      sequencing enable; when low, state holds and
//                            all strobes are 0
//   opcode[3:0], S           IR opcode field and shift direction (1 = right)
//   GPR_in .. Z_out          1-bit datapath strobes
//   GPR_select[2:0]          0 Rd_1, 1 Rd_2, 2 Rs_1, 3 Rs_2, 4 R7 (PC)
//   ALU_control[2:0]         0 pass, 1 add, 2 sub, 3 and, 4 or, 5 bus+1,
//                            6 pass y_shifted
//   halted                   high in HALT
//   illegal                  sticky, set when an undefined opcode is decoded
//   instr_count[15:0]        number of decoded instructions (wraps)
//   state_dbg[3:0]           current state encoding
module control_sequencer (
   input  logic        clk,
   input  logic        reset,
   input  logic        run,
   input  logic [3:0]  opcode,
   input  logic        S,
   output logic        GPR_in,
   output logic        GPR_out,
   output logic        IR_in,
   output logic        MAR_in,
   output logic        MDR_in,
   output logic        MDR_out,
   output logic        RAM_enable_read,
   output logic        RAM_enable_write,
   output logic        Y_in,
   output logic        Y_out,
   output logic        Y_offset_in,
   output logic        Y_shift_left,
   output logic        Y_shift_right,
   output logic        Z_in,
   output logic        Z_out,
   output logic [2:0]  GPR_select,
   output logic [2:0]  ALU_control,
   output logic        halted,
   output logic        illegal,
   output logic [15:0] instr_count,
   output logic [3:0]  state_dbg
);

   typedef enum logic [3:0] {
      IDLE = 4'd0,
      F0   = 4'd1,
      F1   = 4'd2,
      F2   = 4'd3,
      DEC  = 4'd4,
      E0   = 4'd5,
      E1   = 4'd6,
      E2   = 4'd7,
      HALT = 4'd8
   } state_t;

   state_t state;
   state_t state_next;

   logic undefined_op;
   assign undefined_op = (opcode >= 4'h9) && (opcode <= 4'hE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         instr_count <= 16'd0;
         illegal     <= 1'b0;
      end else begin
         state <= state_next;
         // DEC only advances with run high, so gate the count the same way
         if (run && state == DEC) begin
            instr_count <= instr_count + 16'd1;
            if (undefined_op)
               illegal <= 1'b1;
         end
      end
   end

   assign halted    = (state == HALT);
   assign state_dbg = state;

   always_comb begin
      state_next       = state;
      GPR_in           = 1'b0;
      GPR_out          = 1'b0;
      IR_in            = 1'b0;
      MAR_in           = 1'b0;
      MDR_in           = 1'b0;
      MDR_out          = 1'b0;
      RAM_enable_read  = 1'b0;
      RAM_enable_write = 1'b0;
      Y_in             = 1'b0;
      Y_out            = 1'b0;
      Y_offset_in      = 1'b0;
      Y_shift_left     = 1'b0;
      Y_shift_right    = 1'b0;
      Z_in             = 1'b0;
      Z_out            = 1'b0;
      GPR_select       = 3'd0;
      ALU_control      = 3'd0;

      if (run) begin
         case (state)
            IDLE: state_next = F0;
            F0: begin
               // PC -> MAR, PC+1 -> Z
               GPR_out     = 1'b1;
               GPR_select  = 3'd4;
               MAR_in      = 1'b1;
               ALU_control = 3'd5;
               Z_in        = 1'b1;
               state_next  = F1;
            end
            F1: begin
               Z_out           = 1'b1;
               GPR_in          = 1'b1;
               GPR_select      = 3'd4;
               RAM_enable_read = 1'b1;
               state_next      = F2;
            end
            F2: begin
               MDR_out    = 1'b1;
               IR_in      = 1'b1;
               state_next = DEC;
            end
            DEC: begin
               if (opcode == 4'h0)
                  state_next = F0;
               else if (opcode == 4'hF)
                  state_next = HALT;
               else if (undefined_op)
                  state_next = F0;
               else
                  state_next = E0;
            end
            E0: begin
               state_next = E1;
               case (opcode)
                  4'h1, 4'h2: begin
                     GPR_out    = 1'b1;
                     GPR_select = 3'd2;
                     MAR_in     = 1'b1;
                  end
                  4'h3, 4'h4, 4'h5, 4'h6, 4'h8: begin
                     GPR_out    = 1'b1;
                     GPR_select = 3'd2;
                     Y_in       = 1'b1;
                  end
                  4'h7: begin
                     GPR_out     = 1'b1;
                     GPR_select  = 3'd2;
                     ALU_control = 3'd0;
                     Z_in        = 1'b1;
                  end
                  default: state_next = F0;
               endcase
            end
            E1: begin
               state_next = E2;
               case (opcode)
                  4'h1: RAM_enable_read = 1'b1;
                  4'h2: begin
                     GPR_out    = 1'b1;
                     GPR_select = 3'd0;
                     MDR_in     = 1'b1;
                  end
                  4'h3, 4'h4, 4'h5, 4'h6: begin
                     // opcodes 3..6 map onto ALU codes 1..4
                     GPR_out     = 1'b1;
                     GPR_select  = 3'd3;
                     ALU_control = opcode[2:0] - 3'd2;
                     Z_in        = 1'b1;
                  end
                  4'h7: begin
                     Z_out      = 1'b1;
                     GPR_in     = 1'b1;
                     GPR_select = 3'd0;
                     state_next = F0;
                  end
                  4'h8: begin
                     Y_shift_left  = ~S;
                     Y_shift_right = S;
                     ALU_control   = 3'd6;
                     Z_in          = 1'b1;
                  end
                  default: state_next = F0;
               endcase
            end
            E2: begin
               state_next = F0;
               case (opcode)
                  4'h1: begin
                     MDR_out    = 1'b1;
                     GPR_in     = 1'b1;
                     GPR_select = 3'd0;
                  end
                  4'h2: RAM_enable_write = 1'b1;
                  4'h3, 4'h4, 4'h5, 4'h6, 4'h8: begin
                     Z_out      = 1'b1;
                     GPR_in     = 1'b1;
                     GPR_select = 3'd0;
                  end
                  default: ;
               endcase
            end
            HALT:    state_next = HALT;
            default: state_next = IDLE;
         endcase
      end
   end

endmodule
